// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_div_pkg
// Brief   : Shared defaults, divisor type and high-phase helper for the
//           multi-channel clock divider.
// Rev     : 1.0  initial release
// ============================================================================
package clock_div_pkg;

    localparam int CLKDIV_WIDTH_DEF = 32;
    localparam int CLKDIV_NCH_DEF   = 4;
    // Helper arithmetic width; channel widths above this are not supported.
    localparam int CLKDIV_MAXW      = 64;

    typedef logic [CLKDIV_WIDTH_DEF-1:0] div_t;

    // High-phase length in cycles: max(1, div >> 1).
    function automatic logic [CLKDIV_MAXW-1:0] high_phase(input logic [CLKDIV_MAXW-1:0] div);
        logic [CLKDIV_MAXW-1:0] half;
        half = div >> 1;
        if (half == '0) begin
            half = {{(CLKDIV_MAXW-1){1'b0}}, 1'b1};
        end
        return half;
    endfunction

endpackage : clock_div_pkg
`default_nettype wire

// File: rtl/clock_div_chan.sv
`default_nettype none
// ============================================================================
// Module  : clock_div_chan
// Brief   : One divider channel: shadow divisor, period counter, registered
//           divided waveform and period-start strobe. Optional sync input
//           exists when CLKDIV_PHASE_ALIGN_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
import clock_div_pkg::*;

module clock_div_chan #(
    parameter int WIDTH = CLKDIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_i,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] shd_q;
    logic [WIDTH-1:0] shd_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             clk_out_q;
    logic             clk_out_d;
    logic             tick_q;
    logic             tick_d;

    logic [WIDTH-1:0] hp;
    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;
    logic             force_wrap;
    logic             div_nz;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign force_wrap = sync;
`else
    assign force_wrap = 1'b0;
`endif

    assign hp      = WIDTH'(high_phase(CLKDIV_MAXW'(shd_q)));
    assign cnt_inc = cnt_q + WIDTH'(1);
    assign div_nz  = (div_i != '0);
    // An off channel (shd=0) wraps every cycle so a new divisor starts at once.
    assign wrap    = (shd_q == '0) || (cnt_q == (shd_q - WIDTH'(1))) || force_wrap;

    always_comb begin
        shd_d     = shd_q;
        cnt_d     = cnt_inc;
        tick_d    = 1'b0;
        clk_out_d = (cnt_inc < hp);
        if (wrap) begin
            shd_d     = div_i;
            cnt_d     = '0;
            tick_d    = div_nz;
            clk_out_d = div_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shd_q     <= '0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            shd_q     <= shd_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule : clock_div_chan
`default_nettype wire

// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : clock_div_multi
// Brief   : N_CH independent clock dividers with glitch-free runtime
//           divisors. Macro CLKDIV_PHASE_ALIGN_EN adds the sync port.
// Rev     : 1.0  initial release
// ============================================================================
import clock_div_pkg::*;

module clock_div_multi #(
    parameter int N_CH  = CLKDIV_NCH_DEF,
    parameter int WIDTH = CLKDIV_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] div,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic                  sync,
`endif
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            clock_div_chan #(
                .WIDTH   (WIDTH)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .div_i   (div[gi*WIDTH +: WIDTH]),
`ifdef CLKDIV_PHASE_ALIGN_EN
                .sync    (sync),
`endif
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule : clock_div_multi
`default_nettype wire

// File: tb/tb_clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_div_multi
// Brief   : Scoreboard bench for clock_div_multi (4 channels, 8-bit divisors).
// Rev     : 1.0  initial release
// ============================================================================
module tb_clock_div_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic            clk;
    logic            rst;
    logic [NCH*W-1:0] div;
    logic            sync;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NCH-1:0] c;
        logic [NCH-1:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   m_per[NCH];
    int   m_pos[NCH];

    clock_div_multi #(
        .N_CH    (NCH),
        .WIDTH   (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .div     (div),
`ifdef CLKDIV_PHASE_ALIGN_EN
        .sync    (sync),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_div(input int ch, input int v);
        div[ch*W +: W] = W'(v);
    endtask

    // Model thinks in (period, position) terms; pushes the expectation for
    // the upcoming edge, then compares what the DUT shows after it.
    task automatic step();
        exp_t e;
        int   d;
        logic sy;
`ifdef CLKDIV_PHASE_ALIGN_EN
        sy = sync;
`else
        sy = 1'b0;
`endif
        for (int ch = 0; ch < NCH; ch++) begin
            d = int'(div[ch*W +: W]);
            if (rst) begin
                m_per[ch] = 0;
                m_pos[ch] = 0;
            end else if (m_per[ch] == 0 || m_pos[ch] == m_per[ch] - 1 || sy) begin
                m_per[ch] = d;
                m_pos[ch] = 0;
            end else begin
                m_pos[ch] = m_pos[ch] + 1;
            end
            e.t[ch] = (m_per[ch] != 0) && (m_pos[ch] == 0);
            if (m_per[ch] == 0)      e.c[ch] = 1'b0;
            else if (m_per[ch] == 1) e.c[ch] = 1'b1;
            else                     e.c[ch] = (m_pos[ch] < m_per[ch] / 2);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_clk_out", 32'(clk_out), 32'(e.c));
        check("sb_tick", 32'(tick), 32'(e.t));
    endtask

    task automatic wait_ch0_start(input int per, input int limit);
        int n = 0;
        while (!(m_per[0] == per && m_pos[0] == 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check("period_start_timeout", 0, 1);
    endtask

    initial begin
        int gap;
        int highs;
        for (int ch = 0; ch < NCH; ch++) begin
            m_per[ch] = 0;
            m_pos[ch] = 0;
        end
        rst  = 1'b1;
        div  = '0;
        sync = 1'b0;
        step();
        step();
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);

        // Mixed divisors, ch3..ch0 = 0,3,4,2
        rst = 1'b0;
        set_div(0, 2); set_div(1, 4); set_div(2, 3); set_div(3, 0);
        step();
        check("first_edge_tick", 32'(tick), 32'h7);
        check("first_edge_clk", 32'(clk_out), 32'h7);
        for (int i = 0; i < 11; i++) step();

        // Mid-period change 4 -> 2 must finish the old period
        set_div(0, 4);
        wait_ch0_start(4, 10);
        step();
        set_div(0, 2);
        step();
        check("chg_no_runt_a", 32'(clk_out[0]), 0);
        step();
        check("chg_no_runt_b", 32'(clk_out[0]), 0);
        step();
        check("chg_new_tick", 32'(tick[0]), 1);
        for (int i = 0; i < 5; i++) step();

        // div=1 then off
        set_div(0, 1);
        for (int i = 0; i < 4; i++) step();
        check("div1_clk", 32'(clk_out[0]), 1);
        check("div1_tick", 32'(tick[0]), 1);
        set_div(0, 0);
        step();
        check("off_clk", 32'(clk_out[0]), 0);
        check("off_tick", 32'(tick[0]), 0);
        step();

        // Reset mid-period with div=5
        set_div(0, 5);
        wait_ch0_start(5, 10);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_clk", 32'(clk_out), 0);
        check("midrst_tick", 32'(tick), 0);
        rst = 1'b0;
        step();
        check("postrst_tick", 32'(tick[0]), 1);
        check("postrst_clk", 32'(clk_out[0]), 1);
        for (int i = 0; i < 4; i++) step();

        // Maximum divisor 255
        set_div(0, 255);
        wait_ch0_start(255, 10);
        gap   = 0;
        highs = int'(clk_out[0]);
        step();
        gap++;
        while (tick[0] !== 1'b1 && gap < 300) begin
            highs += int'(clk_out[0]);
            step();
            gap++;
        end
        check("max_tick_spacing", 32'(gap), 255);
        check("max_high_cycles", 32'(highs), 127);

`ifdef CLKDIV_PHASE_ALIGN_EN
        set_div(0, 7); set_div(1, 5); set_div(2, 4); set_div(3, 3);
        for (int i = 0; i < 10; i++) step();
        sync = 1'b1;
        step();
        check("sync_aligned_ticks", 32'(tick), 32'hF);
        sync = 1'b0;
        for (int i = 0; i < 30; i++) step();
`endif

        // Random divisor churn
        for (int i = 0; i < 120; i++) begin
            if (i % 6 == 0) begin
                for (int ch = 0; ch < NCH; ch++) set_div(ch, int'($urandom_range(0, 9)));
            end
            rst = ($urandom_range(0, 39) == 0);
`ifdef CLKDIV_PHASE_ALIGN_EN
            sync = ($urandom_range(0, 29) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clock_div_multi
`default_nettype wire
